// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] SEG7_OVF_CODE = 4'hF;

  typedef enum logic {IDLE, CONVERT} seg7_conv_state_t;
  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Largest value representable in the given number of decimal digits.
  function automatic logic [63:0] seg7_max_value(input int unsigned digits);
    logic [63:0] m;
    m = 64'd1;
    for (int unsigned i = 0; i < digits; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble: one shift/add-3 step per clock, BIN_W steps per conversion.
// done_c and bcd_c are combinational and valid in the cycle of the final step.
module seg7_bin2bcd
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              value,
  output logic                          busy,
  output logic                          done_c,
  output bcd_digit_t [DIGITS-1:0]       bcd_c
);

  localparam int unsigned SH_W  = BCD_W * DIGITS + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  seg7_conv_state_t  state, state_d;
  logic [SH_W-1:0]   sh_q, sh_d, adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_d;
  bcd_digit_t        nib;

  // State, shift register and step counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      sh_q  <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      busy  <= busy_d;
    end
  end

  // Next-state: load on start, then add-3 and shift once per cycle.
  always_comb begin
    state_d = state;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    done_c  = 1'b0;
    adj     = sh_q;
    nib     = '0;

    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = sh_q[BIN_W + BCD_W*i +: BCD_W];
      if (nib >= BCD_W'(5)) adj[BIN_W + BCD_W*i +: BCD_W] = nib + BCD_W'(3);
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_d = CONVERT;
          sh_d    = SH_W'(value);
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CONVERT: begin
        sh_d  = {adj[SH_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          done_c  = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < DIGITS; i++) begin
      bcd_c[i] = sh_d[BIN_W + BCD_W*i +: BCD_W];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD conversion plus time-multiplexed digit scanning for seg7_display.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned BIN_W      = 14,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned REFRESH_HZ = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BIN_W-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic              digit_en,
  output logic [3:0]        digit_num,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int unsigned TICK_DIV  = (CLK_HZ / REFRESH_HZ) > 0 ? (CLK_HZ / REFRESH_HZ) : 1;
  localparam int unsigned PRE_W     = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IDX_W     = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [63:0] MAX_VALUE = seg7_max_value(DIGITS);

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  bcd_digit_t [DIGITS-1:0] dig_q, dig_d, bcd_c;
  logic                    ovf_pend, ovf_d, done_c;
  logic [DIGITS-1:0]       sel_d;
  logic [3:0]              num_d;
  logic                    en_d;

  seg7_bin2bcd #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (load),
    .value   (value),
    .busy    (busy),
    .done_c  (done_c),
    .bcd_c   (bcd_c)
  );

  // Scan counters, displayed digits, overflow and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q     <= '0;
      idx_q     <= '0;
      dig_q     <= '0;
      ovf_pend  <= 1'b0;
      overflow  <= 1'b0;
      digit_sel <= ~DIGITS'(1);
      digit_num <= '0;
      digit_en  <= 1'b1;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      dig_q     <= dig_d;
      overflow  <= ovf_d;
      digit_sel <= sel_d;
      digit_num <= num_d;
      digit_en  <= en_d;
      if (load && !busy) ovf_pend <= (64'(value) > MAX_VALUE);
    end
  end

  // Prescaler/index advance and atomic digit update at end of conversion.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    dig_d = dig_q;
    ovf_d = overflow;
    if (pre_q == PRE_W'(TICK_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    if (done_c) begin
      dig_d = bcd_c;
      ovf_d = ovf_pend;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              nz;

  // A digit is blank when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    blank = '0;
    nz    = 1'b0;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      nz       = nz | (dig_d[i] != '0);
      blank[i] = !nz;
    end
  end
`endif

  // Select, number and enable for the digit that will be active next cycle.
  always_comb begin
    sel_d = ~(DIGITS'(1) << idx_d);
    num_d = ovf_d ? SEG7_OVF_CODE : dig_d[idx_d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    en_d  = ovf_d || !blank[idx_d];
`else
    en_d  = 1'b1;
`endif
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a decimal-arithmetic reference model.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int TICK   = 4;
  localparam int MAXV   = 9999;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [BIN_W-1:0]  value;
  logic              load;
  logic              busy, overflow, digit_en;
  logic [3:0]        digit_num;
  logic [DIGITS-1:0] digit_sel;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int k     = 0;   // clock edges since reset release
  int cnt   = 0;   // remaining busy cycles
  int pend  = 0;
  int shown = 0;
  bit m_ovf = 0;

  seg7_scan_driver #(
    .DIGITS     (DIGITS),
    .BIN_W      (BIN_W),
    .CLK_HZ     (1000),
    .REFRESH_HZ (250)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .value     (value),
    .load      (load),
    .busy      (busy),
    .overflow  (overflow),
    .digit_en  (digit_en),
    .digit_num (digit_num),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int idx;
    logic [3:0] sel_e, num_e;
    logic en_e;
    idx   = (k / TICK) % DIGITS;
    sel_e = ~(4'b0001 << idx);
    if (m_ovf) begin
      num_e = 4'hF;
      en_e  = 1'b1;
    end else begin
      num_e = 4'((shown / p10(idx)) % 10);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      en_e  = (idx == 0) || ((shown / p10(idx)) != 0);
`else
      en_e  = 1'b1;
`endif
    end
    chk("busy",      8'(busy),      8'(cnt != 0));
    chk("overflow",  8'(overflow),  8'(m_ovf));
    chk("digit_sel", 8'(digit_sel), 8'(sel_e));
    chk("digit_num", 8'(digit_num), 8'(num_e));
    chk("digit_en",  8'(digit_en),  8'(en_e));
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, then check.
  task automatic step();
    @(posedge clk);
    if (!reset_n) begin
      k = 0; cnt = 0; shown = 0; m_ovf = 0;
    end else begin
      k++;
      if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          m_ovf = pend > MAXV;
          shown = pend % (MAXV + 1);
        end
      end else if (load) begin
        cnt  = BIN_W;
        pend = int'(value);
      end
    end
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_load(input int v);
    value = BIN_W'(v);
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    chk("idle_timeout", 8'(guard < 100), 8'd1);
  endtask

  initial begin
    int busy_len;
    reset_n = 1'b0;
    load    = 1'b0;
    value   = '0;
    steps(3);
    reset_n = 1'b1;

    // Reset release and scan rotation
    steps(20);

    // 1234: busy exactly BIN_W cycles
    pulse_load(1234);
    busy_len = 1;
    while (busy === 1'b1 && busy_len < 100) begin
      step();
      if (busy === 1'b1) busy_len++;
    end
    chk("busy_len_1234", 8'(busy_len), 8'(BIN_W));
    steps(20);

    // Overflow, then cleared by a small value
    pulse_load(10000);
    wait_idle();
    steps(18);
    pulse_load(5);
    wait_idle();
    steps(18);

    // Load while busy is ignored
    pulse_load(42);
    step();
    pulse_load(9999);
    wait_idle();
    steps(18);

    // Reset mid-conversion
    pulse_load(8765);
    steps(5);
    reset_n = 1'b0;
    step();
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_sel",  8'(digit_sel), 8'hE);
    reset_n = 1'b1;
    steps(18);

    // Zero value
    pulse_load(0);
    wait_idle();
    steps(18);

    // Random loads, some landing while busy
    for (int n = 0; n < 30; n++) begin
      int v;
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
      if ($urandom_range(0, 4) == 0) v = int'($urandom_range(0, 99));
      pulse_load(v);
      steps(int'($urandom_range(1, 30)));
    end
    wait_idle();
    steps(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
